// File: rtl/fft_frame_ctrl.sv
// Frame controller around a 32-point FFT core: buffers a source frame, feeds it, collects results, flushes.
// Optional FFT_CTRL_TIMEOUT_EN adds a WAIT watchdog that raises sticky err and flushes the frame.
module fft_frame_ctrl #(
  parameter int FLUSH_CYC = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [11:0] s_din_r,
  input  logic signed [11:0] s_din_i,
  output logic               fft_rst,
  output logic               fft_in_valid,
  output logic        [11:0] fft_din_r,
  output logic        [11:0] fft_din_i,
  input  logic               fft_out_valid,
  input  logic        [15:0] fft_dout_r,
  input  logic        [15:0] fft_dout_i,
  output logic               m_valid,
  output logic        [15:0] m_dout_r,
  output logic        [15:0] m_dout_i,
  output logic        [4:0]  m_index,
  output logic               m_last,
  output logic               busy,
  output logic               err,
  output logic        [15:0] frames_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYC - 1);

  if (FLUSH_CYC < 1 || FLUSH_CYC > 15 || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_param
    $error("fft_frame_ctrl: FLUSH_CYC or TIMEOUT out of range");
  end

  logic [2:0]  state, state_nxt;
  logic [4:0]  wr_idx;
  logic [4:0]  rd_idx;
  logic [3:0]  flush_cnt;
  logic [23:0] buf_mem [32];
  logic        accept;
  logic        timeout_hit;

  assign accept = s_ready & s_valid;

`ifdef FFT_CTRL_TIMEOUT_EN
  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);
  logic [9:0] wait_cnt;
  assign timeout_hit = (wait_cnt == WAIT_LAST);
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_FILL;
      S_FILL:  if (accept && wr_idx == 5'd31) state_nxt = S_FEED;
      S_FEED:  if (rd_idx == 5'd0) state_nxt = S_WAIT;
      S_WAIT: begin
        if (fft_out_valid)    state_nxt = S_DRAIN;
        else if (timeout_hit) state_nxt = S_FLUSH;
      end
      S_DRAIN: if (m_index == 5'd31) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = enable ? S_FILL : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the sample buffer is deliberately left out of reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[wr_idx] <= {s_din_r, s_din_i};
  end

  // NOTE: all registers use non-blocking assignments so every decision sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      s_ready      <= 1'b0;
      fft_rst      <= 1'b1;
      fft_in_valid <= 1'b0;
      fft_din_r    <= '0;
      fft_din_i    <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_dout_r     <= '0;
      m_dout_i     <= '0;
      m_index      <= '0;
      frames_done  <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      flush_cnt    <= '0;
    end else begin
      // Status and strobes are decoded from the next state so they line up with it.
      state        <= state_nxt;
      busy         <= (state_nxt != S_IDLE);
      s_ready      <= (state_nxt == S_FILL);
      fft_rst      <= (state_nxt == S_FLUSH);
      fft_in_valid <= (state_nxt == S_FEED);
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      case (state)
        S_FILL: begin
          if (accept) begin
            wr_idx <= wr_idx + 5'd1;
            if (wr_idx == 5'd31) begin
              fft_din_r <= buf_mem[0][23:12];
              fft_din_i <= buf_mem[0][11:0];
              rd_idx    <= 5'd1;
            end
          end
        end
        S_FEED: begin
          // rd_idx wraps to 0 once buffer[31] has been presented.
          if (rd_idx != 5'd0) begin
            fft_din_r <= buf_mem[rd_idx][23:12];
            fft_din_i <= buf_mem[rd_idx][11:0];
            rd_idx    <= rd_idx + 5'd1;
          end
        end
        S_WAIT: begin
          if (fft_out_valid) begin
            m_valid  <= 1'b1;
            m_dout_r <= fft_dout_r;
            m_dout_i <= fft_dout_i;
            m_index  <= 5'd0;
          end
        end
        S_DRAIN: begin
          if (m_index != 5'd31) begin
            m_valid  <= 1'b1;
            m_dout_r <= fft_dout_r;
            m_dout_i <= fft_dout_i;
            m_index  <= m_index + 5'd1;
            if (m_index == 5'd30) begin
              m_last      <= 1'b1;
              frames_done <= frames_done + 16'd1;
            end
          end
        end
        S_FLUSH: begin
          flush_cnt <= (flush_cnt == FLUSH_LAST) ? 4'd0 : flush_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 10'd1;
      if (!fft_out_valid && timeout_hit) err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized frame-level bench for fft_frame_ctrl with an FFT-core stand-in and a queue-based reference.
module tb_fft_frame_ctrl;

  localparam int FLUSH_CYC  = 2;
  localparam int TB_TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               s_valid;
  logic               s_ready;
  logic signed [11:0] s_din_r, s_din_i;
  logic               fft_rst, fft_in_valid;
  logic        [11:0] fft_din_r, fft_din_i;
  logic               fft_out_valid;
  logic        [15:0] fft_dout_r, fft_dout_i;
  logic               m_valid, m_last, busy, err;
  logic        [15:0] m_dout_r, m_dout_i, frames_done;
  logic        [4:0]  m_index;

  int checks   = 0;
  int failures = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.FLUSH_CYC(FLUSH_CYC), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_din_r(s_din_r), .s_din_i(s_din_i),
    .fft_rst(fft_rst), .fft_in_valid(fft_in_valid), .fft_din_r(fft_din_r), .fft_din_i(fft_din_i),
    .fft_out_valid(fft_out_valid), .fft_dout_r(fft_dout_r), .fft_dout_i(fft_dout_i),
    .m_valid(m_valid), .m_dout_r(m_dout_r), .m_dout_i(m_dout_i), .m_index(m_index), .m_last(m_last),
    .busy(busy), .err(err), .frames_done(frames_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_fft_rst", fft_rst, 1);
    check("rst_s_ready", s_ready, 0);
    check("rst_in_valid", fft_in_valid, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_frames", frames_done, 0);
    check("rst_m_index", m_index, 0);
    check("rst_m_dout", {m_dout_r, m_dout_i}, 0);
    check("rst_fft_din", {fft_din_r, fft_din_i}, 0);
  endtask

  // One frame end to end. Main flow always sits on a falling edge.
  task automatic run_frame(input bit seq, input bit gap, input bit junk, input bit drop,
                           input int lat, input int abort_idx, input bit hang);
    logic [23:0] in_q[$];
    logic [31:0] x[32];
    logic [23:0] smp, got, exp_s, last_s;
    int n;

    for (int k = 0; k < 32; k++) x[k] = seq ? {16'(k), 16'(31 - k)} : $urandom;

    n = 0;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    check("fill_ready", s_ready, 1);

    for (int i = 0; i < 32; i++) begin
      smp = seq ? {12'(i + 1), 12'(i + 1)} : 24'($urandom);
      check("fill_ready_each", s_ready, 1);
      in_q.push_back(smp);
      last_s  = smp;
      s_valid = 1'b1;
      {s_din_r, s_din_i} = smp;
      @(negedge clk);
      if (gap && (i % 5 == 4) && i != 31) begin
        s_valid = 1'b0;
        {s_din_r, s_din_i} = 24'($urandom);
        repeat (3) @(negedge clk);
      end
    end
    s_valid = 1'b0;
    check("ready_fall", s_ready, 0);
    check("feed_start", fft_in_valid, 1);
    check("busy_feed", busy, 1);

    n = 0;
    while (fft_in_valid && n < 40) begin
      got = {fft_din_r, fft_din_i};
      exp_s = (in_q.size() > 0) ? in_q.pop_front() : ~got;
      check("feed_data", got, exp_s);
      n++;
      fft_out_valid = junk;
      {fft_dout_r, fft_dout_i} = $urandom;
      if (drop) enable = 1'b0;
      @(negedge clk);
    end
    fft_out_valid = 1'b0;
    check("feed_len", n, 32);
    check("feed_hold", {fft_din_r, fft_din_i}, last_s);

    if (hang) begin
`ifdef FFT_CTRL_TIMEOUT_EN
      n = 1;
      while (!err && n <= TB_TIMEOUT + 10) begin @(negedge clk); n++; end
      check("timeout_cycle", n, TB_TIMEOUT + 1);
      check("timeout_flush", fft_rst, 1);
      check("timeout_frames", frames_done, exp_frames);
`else
      repeat (100) begin
        check("hang_stay", {err, busy, m_valid, fft_rst}, 4'b0100);
        @(negedge clk);
      end
`endif
      return;
    end

    repeat (lat) begin
      check("wait_quiet", m_valid, 0);
      @(negedge clk);
    end

    for (int t = 0; t <= 32; t++) begin
      if (t >= 1) begin
        check("m_valid", m_valid, 1);
        check("m_index", m_index, t - 1);
        check("m_dout", {m_dout_r, m_dout_i}, x[t-1]);
        check("m_last", m_last, (t == 32));
      end else begin
        check("m_valid_pre", m_valid, 0);
      end
      if (abort_idx >= 0 && t == abort_idx + 1) begin
        reset = 1'b1;
        #1;
        check_reset_vals();
        fft_out_valid = 1'b0;
        exp_frames = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_fft_rst_fall", fft_rst, 0);
        repeat (5) begin
          check("abort_no_mvalid", m_valid, 0);
          @(negedge clk);
        end
        return;
      end
      if (t < 32) begin
        fft_out_valid = 1'b1;
        {fft_dout_r, fft_dout_i} = x[t];
      end else begin
        fft_out_valid = 1'b0;
        {fft_dout_r, fft_dout_i} = $urandom;
      end
      @(negedge clk);
    end

    exp_frames = (exp_frames + 1) % 65536;
    check("post_m_valid", m_valid, 0);
    check("post_m_last", m_last, 0);
    check("m_hold", {m_dout_r, m_dout_i, 3'b0, m_index}, {x[31], 8'd31});
    check("frames_done", frames_done, exp_frames);

    n = 0;
    while (fft_rst && n < 20) begin n++; @(negedge clk); end
    check("flush_len", n, FLUSH_CYC);
    check("post_flush_ready", s_ready, enable);
    check("post_flush_busy", busy, enable);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    s_valid = 1'b0;
    s_din_r = '0;
    s_din_i = '0;
    fft_out_valid = 1'b0;
    fft_dout_r = '0;
    fft_dout_i = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    check("release_fft_rst", fft_rst, 0);
    check("idle_busy", busy, 0);

    enable = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 40, -1, 1'b0);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, $urandom_range(20, 50), -1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(20, 50), -1, 1'b0);
    check("three_frames", frames_done, 3);
    repeat (3) begin
      check("idle_after_drop", {busy, s_ready}, 2'b00);
      @(negedge clk);
    end

    enable = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(20, 50), 10, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, $urandom_range(20, 50), -1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b1);

    reset = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
